// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: lap-controller state encoding and system-level defaults.
package stopwatch_pkg;

  localparam int CLK_FREQ_HZ         = 100_000_000;
  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 2 * CLK_FREQ_HZ;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [2:0] {
    LIVE   = 3'b001,
    HOLD   = 3'b010,
    REVIEW = 3'b100
  } lap_state_e;

endpackage

// File: rtl/lap_mem.sv
// Lap storage: DEPTH x WIDTH register file, synchronous write, asynchronous read.
module lap_mem
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the controller never reads a slot before writing it,
  // and leaving it unreset lets the array map onto plain flops or distributed RAM.
  // NOTE: clocked state is always assigned with <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_ctl.sv
// Lap/split controller: captures split times, freezes the display during hold,
// and steps through stored laps while the stopwatch is paused.
module lap_ctl
  import stopwatch_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_regs,
  input  logic             count_enabled,
  input  logic             split,
  input  logic             review,
  input  logic [WIDTH-1:0] time_in,
  output logic [WIDTH-1:0] disp_time,
  output logic             disp_lap,
  output logic [AW-1:0]    lap_sel,
  output logic [AW:0]      lap_count,
  output logic             lap_full
);

  localparam int          TW         = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] SEL_ONE    = AW'(1);

  lap_state_e       state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [AW-1:0]    sel_n;
  logic [AW:0]      count_n;
  logic             we;
  logic             capture;
  logic [WIDTH-1:0] rdata;

  lap_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (lap_count[AW-1:0]),
    .wdata (time_in),
    .raddr (lap_sel),
    .rdata (rdata)
  );

  assign capture = split && count_enabled && !lap_full;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    timer_n = timer;
    sel_n   = lap_sel;
    count_n = lap_count;
    we      = 1'b0;

    if (init_regs) begin
      state_n = LIVE;
      timer_n = '0;
      sel_n   = '0;
      count_n = '0;
    end else if (capture && state != REVIEW) begin
      we      = 1'b1;
      sel_n   = lap_count[AW-1:0];
      count_n = lap_count + CNT_ONE;
      timer_n = HOLD_LOAD;
      state_n = HOLD;
    end else begin
      case (state)
        LIVE: begin
          if (review && !count_enabled && lap_count != '0) begin
            state_n = REVIEW;
            sel_n   = '0;
          end
        end
        HOLD: begin
          if (timer == '0) state_n = LIVE;
          else             timer_n = timer - TIMER_ONE;
        end
        REVIEW: begin
          // A split here is the stop-to-reset gesture; resume also returns to live.
          if (split || count_enabled) begin
            state_n = LIVE;
          end else if (review) begin
            sel_n = ({1'b0, lap_sel} == lap_count - CNT_ONE) ? '0 : lap_sel + SEL_ONE;
          end
        end
        default: state_n = LIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LIVE;
      timer     <= '0;
      lap_sel   <= '0;
      lap_count <= '0;
      lap_full  <= 1'b0;
      disp_time <= '0;
      disp_lap  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      lap_sel   <= sel_n;
      lap_count <= count_n;
      lap_full  <= (count_n == FULL_COUNT);
      disp_time <= (state == LIVE) ? time_in : rdata;
      disp_lap  <= (state != LIVE);
    end
  end

endmodule

// File: tb/tb_lap_ctl.sv
// Directed bench for lap_ctl with DEPTH=4, HOLD_CYCLES=8; display values go through a scoreboard queue.
module tb_lap_ctl;
  import stopwatch_pkg::*;

  localparam int WIDTH       = 16;
  localparam int DEPTH       = 4;
  localparam int HOLD_CYCLES = 8;
  localparam int AW          = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset, init_regs, count_enabled, split, review;
  logic [WIDTH-1:0] time_in;
  logic [WIDTH-1:0] disp_time;
  logic             disp_lap;
  logic [AW-1:0]    lap_sel;
  logic [AW:0]      lap_count;
  logic             lap_full;

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  lap_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk           (clk),
    .reset         (reset),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .split         (split),
    .review        (review),
    .time_in       (time_in),
    .disp_time     (disp_time),
    .disp_lap      (disp_lap),
    .lap_sel       (lap_sel),
    .lap_count     (lap_count),
    .lap_full      (lap_full)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [WIDTH-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %0h expected <nothing queued>", tag, disp_time);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(disp_time), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; init_regs = 1'b0; count_enabled = 1'b0;
    split = 1'b0; review = 1'b0; time_in = '0;
    step(2);
    check("rst_disp_time", 32'(disp_time), 0);
    check("rst_disp_lap",  32'(disp_lap),  0);
    check("rst_lap_sel",   32'(lap_sel),   0);
    check("rst_lap_count", 32'(lap_count), 0);
    check("rst_lap_full",  32'(lap_full),  0);

    // Idle: display follows live time one cycle behind.
    reset = 1'b0; init_regs = 1'b1; time_in = 16'h0042;
    sb_push(16'h0042);
    step(1);
    init_regs = 1'b0;
    sb_check("idle_live");

    // Single split at 0x0123, then 8 cycles of frozen display.
    count_enabled = 1'b1; time_in = 16'h0123; split = 1'b1;
    step(1);
    split = 1'b0;
    check("cap1_count", 32'(lap_count), 1);
    check("cap1_sel",   32'(lap_sel),   0);
    check("cap1_lap",   32'(disp_lap),  0);
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      time_in = 16'(16'h0200 + i);
      sb_push(16'h0123);
      step(1);
      check("hold1_lap", 32'(disp_lap), 1);
      sb_check("hold1_time");
    end
    time_in = 16'h0300; sb_push(16'h0300);
    step(1);
    check("hold1_end_lap", 32'(disp_lap), 0);
    sb_check("hold1_end_time");
    time_in = 16'h0301; sb_push(16'h0301);
    step(1);
    sb_check("live_track");

    // Four splits three cycles apart, then a fifth while full.
    init_regs = 1'b1; count_enabled = 1'b0;
    step(1);
    init_regs = 1'b0;
    check("init_count", 32'(lap_count), 0);
    count_enabled = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      time_in = 16'(16'h1000 + k); split = 1'b1;
      step(1);
      split = 1'b0;
      check("split_count", 32'(lap_count), k + 1);
      check("split_sel",   32'(lap_sel),   k);
      check("split_full",  32'(lap_full),  (k == DEPTH - 1) ? 1 : 0);
      time_in = 16'h2000;
      sb_push(16'(16'h1000 + k));
      step(1);
      check("split_hold_lap", 32'(disp_lap), 1);
      sb_check("split_hold_time");
      step(1);
    end
    time_in = 16'h1FFF; split = 1'b1; sb_push(16'h1003);
    step(1);
    split = 1'b0;
    check("full_count", 32'(lap_count), DEPTH);
    check("full_sel",   32'(lap_sel),   DEPTH - 1);
    check("full_flag",  32'(lap_full),  1);
    sb_check("full_time");
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("full_hold_lap", 32'(disp_lap), 1);
    end
    step(1);
    check("full_hold_end", 32'(disp_lap), 0);

    // Paused review of four laps: confirms the fifth split wrote nothing.
    count_enabled = 1'b0;
    for (int j = 0; j < 5; j++) begin
      review = 1'b1;
      step(1);
      review = 1'b0;
      check("rev4_sel", 32'(lap_sel), j % DEPTH);
      sb_push(16'(16'h1000 + j % DEPTH));
      step(1);
      check("rev4_lap", 32'(disp_lap), 1);
      sb_check("rev4_time");
    end

    // Reset while reviewing with a full memory.
    reset = 1'b1; time_in = 16'h0777;
    step(1);
    reset = 1'b0;
    check("rrst_disp_time", 32'(disp_time), 0);
    check("rrst_disp_lap",  32'(disp_lap),  0);
    check("rrst_lap_sel",   32'(lap_sel),   0);
    check("rrst_lap_count", 32'(lap_count), 0);
    check("rrst_lap_full",  32'(lap_full),  0);
    sb_push(16'h0777);
    step(1);
    sb_check("rrst_live");

    // Three laps back to back, then five review pulses.
    count_enabled = 1'b1;
    for (int k = 0; k < 3; k++) begin
      time_in = 16'(16'h0010 * (k + 1)); split = 1'b1;
      step(1);
    end
    split = 1'b0;
    check("three_count", 32'(lap_count), 3);
    check("three_full",  32'(lap_full),  0);
    step(HOLD_CYCLES + 1);
    check("three_hold_end", 32'(disp_lap), 0);
    count_enabled = 1'b0;
    for (int j = 0; j < 5; j++) begin
      review = 1'b1;
      step(1);
      review = 1'b0;
      sb_push(16'(16'h0010 * (j % 3 + 1)));
      step(1);
      sb_check("rev3_time");
    end
    split = 1'b1;
    step(1);
    split = 1'b0;
    step(1);
    check("rev_split_exit", 32'(disp_lap),  0);
    check("rev_split_cnt",  32'(lap_count), 3);
    review = 1'b1;
    step(1);
    review = 1'b0;
    check("rev_reenter_sel", 32'(lap_sel), 0);
    step(1);
    check("rev_reenter_lap", 32'(disp_lap), 1);
    count_enabled = 1'b1;
    step(2);
    check("rev_resume_exit", 32'(disp_lap), 0);
    init_regs = 1'b1; count_enabled = 1'b0;
    step(1);
    init_regs = 1'b0;

    // Review with no laps stored stays live.
    time_in = 16'h0ABC; review = 1'b1;
    step(1);
    review = 1'b0;
    sb_push(16'h0ABC);
    step(1);
    check("empty_rev_lap", 32'(disp_lap), 0);
    check("empty_rev_sel", 32'(lap_sel),  0);
    sb_check("empty_rev_time");

    // Split and review together while counting: capture wins.
    count_enabled = 1'b1; time_in = 16'h0555; split = 1'b1; review = 1'b1;
    step(1);
    split = 1'b0; review = 1'b0;
    check("both_count", 32'(lap_count), 1);
    check("both_sel",   32'(lap_sel),   0);
    time_in = 16'h0556; sb_push(16'h0555);
    step(1);
    check("both_lap", 32'(disp_lap), 1);
    sb_check("both_time");

    // init_regs during hold.
    init_regs = 1'b1; count_enabled = 1'b0;
    step(1);
    init_regs = 1'b0;
    check("ihold_count", 32'(lap_count), 0);
    check("ihold_full",  32'(lap_full),  0);
    check("ihold_sel",   32'(lap_sel),   0);
    sb_push(16'h0556);
    step(1);
    check("ihold_lap", 32'(disp_lap), 0);
    sb_check("ihold_time");

    // Reset during hold leaves no pending timeout.
    count_enabled = 1'b1; time_in = 16'h0999; split = 1'b1;
    step(1);
    split = 1'b0;
    check("hrst_cap", 32'(lap_count), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("hrst_count", 32'(lap_count), 0);
    step(2);
    check("hrst_lap", 32'(disp_lap), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lap_ctl.md
# lap_ctl

Lap/split controller between the stopwatch control FSM and the display driver. While the stopwatch counts, each `split` pulse captures the live time into a small lap memory and freezes the display on that lap for a fixed hold period. While the stopwatch is paused, `review` steps through the stored laps. The block never drives the Counter; it consumes `init_regs`/`count_enabled` and selects what the display shows.

## Interface
- `WIDTH`, 16: width of the time value (BCD digits packed).
- `DEPTH`, 4: number of lap slots, power of two, at least 2.
- `HOLD_CYCLES`, 200_000_000: display-freeze duration in clk cycles (2 s at 100 MHz); at least 2.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; one clock; all state is cleared on the next edge.
- `init_regs` input 1: level from the control FSM; high means idle, so lap memory is cleared.
- `count_enabled` input 1: level from the control FSM; high means counting.
- `split` input 1: debounced single-cycle pulse.
- `review` input 1: debounced single-cycle pulse.
- `time_in` input WIDTH: live Counter value.
- `disp_time` output WIDTH: registered value to display.
- `disp_lap` output 1: registered; high when `disp_time` is a stored lap.
- `lap_sel` output log2(DEPTH): registered index of the displayed or last-written lap.
- `lap_count` output log2(DEPTH)+1: number of stored laps, 0..DEPTH.
- `lap_full` output 1: `lap_count == DEPTH`, registered.

## Operation
- FSM states are one-hot: LIVE, HOLD, REVIEW. Reset goes to LIVE.
- Priority: `reset` > `init_regs` > `split` > `review` > hold timeout.
- `init_regs` high, any state: next state LIVE, `lap_count` 0, `lap_sel` 0. Memory contents need not be cleared because they are never read when the count is 0.
- Capture condition is `split && count_enabled && !lap_full`.
  - Writes `time_in` of that cycle to slot `lap_count`.
  - `lap_sel` is set to that slot.
  - `lap_count` increments.
  - Next state is HOLD, with the hold timer loaded.
  - Applies in LIVE and in HOLD; in HOLD it restarts the timer.
- Split when full while counting: no write and no state change.
- Split while not counting:
  - In LIVE or HOLD it is ignored.
  - In REVIEW it exits to LIVE. The control FSM also reacts to it, and `init_regs` follows.
- HOLD:
  - Display shows `mem[lap_sel]`.
  - The timer decrements every cycle and goes to LIVE when it expires.
  - `review` is ignored.
  - If `count_enabled` drops, HOLD continues until timeout.
- LIVE with `review && !count_enabled && lap_count != 0`: go to REVIEW with `lap_sel` 0. The same request with `lap_count == 0` is ignored.
- REVIEW:
  - Display shows `mem[lap_sel]`.
  - Each `review` advances `lap_sel`; it wraps from `lap_count-1` to 0.
  - `count_enabled` high (resume) goes to LIVE.
- Display source:
  - LIVE: `disp_time` is `time_in`, `disp_lap` 0.
  - HOLD and REVIEW: `disp_time` is the memory read at `lap_sel`, `disp_lap` 1.

## Timing
- Reset values: `disp_time` 0, `disp_lap` 0, `lap_sel` 0, `lap_count` 0, `lap_full` 0, state LIVE, hold timer 0.
- All outputs are registered.
- In LIVE, `disp_time` trails `time_in` by 1 cycle.
- Capture on edge N (split high before edge N):
  - At edge N: memory written, `lap_count`/`lap_sel` updated, state HOLD.
  - At edge N+1: `disp_time` equals the captured value and `disp_lap` is 1.
- Hold length:
  - The timer loads `HOLD_CYCLES-1` and counts to 0.
  - The FSM spends exactly `HOLD_CYCLES` cycles in HOLD.
  - `disp_lap` falls 1 cycle after the return to LIVE.
- A review step changes `lap_sel` at the same edge; `disp_time` follows 1 cycle later.
- `lap_full` asserts in the same edge that writes slot DEPTH-1.
- `init_regs` asserted in HOLD or REVIEW: state is LIVE at the next edge, and `disp_lap` is 0 one cycle after that.
- Reset mid-HOLD: the timer is discarded and there is no pending timeout.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the one-hot state localparams (LIVE=3'b001, HOLD=3'b010, REVIEW=3'b100);
  - `WIDTH` and `HOLD_CYCLES` defaults;
  - the clk frequency constant.
- Sub-module `lap_mem`:
  - DEPTH×WIDTH register file;
  - synchronous write (`we`, `waddr`, `wdata`), asynchronous read (`raddr`, `rdata`);
  - no reset on storage.
- `lap_ctl` holds the FSM, hold timer, counters and output registers.

## Test plan
Benches run with `HOLD_CYCLES`=8 and `DEPTH`=4.
- Counting, `time_in`=0x0123, one split -> slot 0 = 0x0123; `lap_count` 1; `disp_lap` 1 for 8 cycles; afterwards `disp_time` tracks `time_in`.
- Four splits 3 cycles apart while counting -> each restarts hold; `lap_count` 4 and `lap_full` 1; a fifth split leaves the memory and state unchanged.
- Paused with 3 laps {0x0010, 0x0020, 0x0030}, five `review` pulses -> displays 0x0010, 0x0020, 0x0030, 0x0010, 0x0020.
- `review` while paused with `lap_count` 0 -> stays LIVE and `disp_lap` stays 0.
- `split` and `review` in the same cycle while counting -> capture happens and `review` has no effect.
- `init_regs` pulse in HOLD, and separately `reset` in REVIEW -> LIVE next edge; `lap_count` 0; `lap_full` 0; all outputs at their reset or live values.
